// File: rtl/apu_frame_counter.sv
// APU frame sequencer: paces quarter/half-frame clocks for the sound channels
// and raises the frame IRQ in 4-step mode.
module apu_frame_counter (
    input  logic clk,
    input  logic rst_l,
    input  logic cpu_clk_en,
    input  logic apu_clk_en,
    input  logic mode_wr,
    input  logic mode_in,
    input  logic irq_inhibit_in,
    input  logic status_rd,
    output logic quarter_clk_en,
    output logic half_clk_en,
    output logic frame_irq,
    output logic mode
);

    localparam logic [14:0] TERM_4STEP = 15'd14914;
    localparam logic [14:0] TERM_5STEP = 15'd18640;
    localparam logic [14:0] STEP_HALF  = 15'd7456;
    // Interior quarter-frame points, packed so generate can slice them.
    localparam logic [44:0] QUARTER_PTS = {15'd11185, 15'd7456, 15'd3728};

    logic [14:0] c_reg, c_next;
    logic        mode_reg, mode_next;
    logic        irq_inhibit_reg, irq_inhibit_next;
    logic        pending_reg, pending_next;
    logic        frame_irq_reg, frame_irq_next;

    logic [14:0] term;
    logic        wr_acc;
    logic        rd_acc;
    logic        step;
    logic        at_term;
    logic        irq_set;
    logic        irq_clr;
    logic [2:0]  q_hit;

    assign wr_acc  = cpu_clk_en & mode_wr;
    assign rd_acc  = cpu_clk_en & status_rd;
    assign term    = mode_reg ? TERM_5STEP : TERM_4STEP;
    assign at_term = (c_reg == term);
    // A register write takes priority over any sequencer step in the same cycle.
    assign step    = apu_clk_en & ~wr_acc;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_quarter
            assign q_hit[gi] = (c_reg == QUARTER_PTS[gi*15 +: 15]);
        end
    endgenerate

    assign quarter_clk_en = step & ((|q_hit) | at_term | pending_reg);
    assign half_clk_en    = step & ((c_reg == STEP_HALF) | at_term | pending_reg);

    assign irq_set = step & ~mode_reg & ~irq_inhibit_reg & (c_reg == TERM_4STEP);
    assign irq_clr = rd_acc | (wr_acc & irq_inhibit_in);

    always_comb begin
        c_next           = c_reg;
        mode_next        = mode_reg;
        irq_inhibit_next = irq_inhibit_reg;
        pending_next     = pending_reg;
        frame_irq_next   = frame_irq_reg;

        if (wr_acc) begin
            c_next           = '0;
            mode_next        = mode_in;
            irq_inhibit_next = irq_inhibit_in;
            pending_next     = mode_in;
        end else if (apu_clk_en) begin
            c_next       = at_term ? 15'd0 : c_reg + 15'd1;
            pending_next = 1'b0;
        end

        if (irq_set) begin
            frame_irq_next = 1'b1;
        end else if (irq_clr) begin
            frame_irq_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            c_reg           <= '0;
            mode_reg        <= 1'b0;
            irq_inhibit_reg <= 1'b0;
            pending_reg     <= 1'b0;
            frame_irq_reg   <= 1'b0;
        end else begin
            c_reg           <= c_next;
            mode_reg        <= mode_next;
            irq_inhibit_reg <= irq_inhibit_next;
            pending_reg     <= pending_next;
            frame_irq_reg   <= frame_irq_next;
        end
    end

    assign frame_irq = frame_irq_reg;
    assign mode      = mode_reg;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter: checks pulse positions per sequence,
// IRQ set/clear priorities, write-vs-step priority and reset behaviour.
module tb_apu_frame_counter;

    logic clk = 1'b0;
    logic rst_l = 1'b0;
    logic cpu_clk_en = 1'b0;
    logic apu_clk_en = 1'b0;
    logic mode_wr = 1'b0;
    logic mode_in = 1'b0;
    logic irq_inhibit_in = 1'b0;
    logic status_rd = 1'b0;
    logic quarter_clk_en;
    logic half_clk_en;
    logic frame_irq;
    logic mode;

    int tests_run = 0;
    int tests_failed = 0;
    int qpos[$];
    int hpos[$];
    int exp_q[$];
    int irq_first;

    apu_frame_counter dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .cpu_clk_en     (cpu_clk_en),
        .apu_clk_en     (apu_clk_en),
        .mode_wr        (mode_wr),
        .mode_in        (mode_in),
        .irq_inhibit_in (irq_inhibit_in),
        .status_rd      (status_rd),
        .quarter_clk_en (quarter_clk_en),
        .half_clk_en    (half_clk_en),
        .frame_irq      (frame_irq),
        .mode           (mode)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clk cycle: inputs applied at negedge, comb outputs sampled before
    // the posedge, strobes dropped just after it.
    task automatic cyc(input bit apu, input bit wr, input bit m, input bit inh,
                       input bit rd, output bit q, output bit h);
        @(negedge clk);
        cpu_clk_en     = 1'b1;
        apu_clk_en     = apu;
        mode_wr        = wr;
        mode_in        = m;
        irq_inhibit_in = inh;
        status_rd      = rd;
        #1;
        q = quarter_clk_en;
        h = half_clk_en;
        @(posedge clk);
        #1;
        apu_clk_en = 1'b0;
        mode_wr    = 1'b0;
        status_rd  = 1'b0;
    endtask

    // Runs n APU steps, recording step indices with quarter/half pulses and
    // the first step after which frame_irq reads high.
    task automatic run_apu(input int n, input int rd_at);
        bit q, h;
        qpos.delete();
        hpos.delete();
        irq_first = -1;
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, (i == rd_at), q, h);
            if (q) qpos.push_back(i);
            if (h) hpos.push_back(i);
            if (frame_irq && irq_first < 0) irq_first = i;
        end
    endtask

    task automatic check_pos(input string tag, input bit is_half);
        int n = is_half ? hpos.size() : qpos.size();
        check({tag, "_cnt"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++) begin
            check($sformatf("%s_%0d", tag, i), is_half ? hpos[i] : qpos[i], exp_q[i]);
        end
    endtask

    initial begin
        bit q, h;

        // Reset state with an active APU qualifier
        repeat (2) @(negedge clk);
        cpu_clk_en = 1'b1;
        apu_clk_en = 1'b1;
        #1;
        check("rst_quarter", quarter_clk_en, 0);
        check("rst_half", half_clk_en, 0);
        check("rst_irq", frame_irq, 0);
        check("rst_mode", mode, 0);
        @(negedge clk);
        apu_clk_en = 1'b0;
        rst_l = 1'b1;

        // 4-step period; status read coincides with the IRQ-setting step
        run_apu(14915, 14914);
        exp_q = '{3728, 7456, 11185, 14914};
        check_pos("p4_q", 1'b0);
        exp_q = '{7456, 14914};
        check_pos("p4_h", 1'b1);
        check("p4_irq_rise", irq_first, 14914);

        // Inhibit write clears the flag; no IRQ while inhibited
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, q, h);
        check("inh_irq_clr", frame_irq, 0);
        check("inh_mode", mode, 0);
        run_apu(18644, -1);
        exp_q = '{3728, 7456, 11185, 14914, 18643};
        check_pos("inh_q", 1'b0);
        exp_q = '{7456, 14914};
        check_pos("inh_h", 1'b1);
        check("inh_irq_none", irq_first, -1);

        // Write landing on the c=7456 step
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, q, h);
        run_apu(7456, -1);
        exp_q = '{3728};
        check_pos("pre_q", 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, q, h);
        check("idle_q", q, 0);
        check("idle_h", h, 0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, q, h);
        check("wrstep_q", q, 0);
        check("wrstep_h", h, 0);
        run_apu(14915, -1);
        exp_q = '{3728, 7456, 11185, 14914};
        check_pos("post_q", 1'b0);
        exp_q = '{7456, 14914};
        check_pos("post_h", 1'b1);
        check("post_irq_rise", irq_first, 14914);

        // Plain status read clears the flag
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, q, h);
        check("rd_irq_clr", frame_irq, 0);

        // 5-step mode with immediate pulse
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, q, h);
        check("m5_mode", mode, 1);
        run_apu(18642, -1);
        exp_q = '{0, 3728, 7456, 11185, 18640};
        check_pos("m5_q", 1'b0);
        exp_q = '{0, 7456, 18640};
        check_pos("m5_h", 1'b1);
        check("m5_irq_none", irq_first, -1);

        // Reset with a pending 5-step pulse
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, q, h);
        @(negedge clk);
        rst_l = 1'b0;
        cpu_clk_en = 1'b1;
        apu_clk_en = 1'b1;
        #1;
        check("mrst_quarter", quarter_clk_en, 0);
        check("mrst_half", half_clk_en, 0);
        check("mrst_irq", frame_irq, 0);
        check("mrst_mode", mode, 0);
        @(negedge clk);
        apu_clk_en = 1'b0;
        rst_l = 1'b1;
        run_apu(3729, -1);
        exp_q = '{3728};
        check_pos("mrst_q", 1'b0);
        exp_q = '{};
        check_pos("mrst_h", 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/apu_frame_counter.md
APU_FRAME_COUNTER -- requirements
Module: apu_frame_counter

Interface
REQ-001 SHALL have parameters: none. Sequence step points are fixed in REQ-011/012.
REQ-002 SHALL have port clk, input, 1, system clock.
REQ-003 SHALL have port rst_l, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port cpu_clk_en, input, 1, CPU-cycle qualifier.
REQ-005 SHALL have port apu_clk_en, input, 1, APU-cycle qualifier. It is asserted only in cycles where cpu_clk_en=1, i.e. every second CPU cycle.
REQ-006 SHALL have port mode_wr, input, 1, $4017 write strobe. It is valid only when cpu_clk_en=1.
REQ-007 SHALL have port mode_in, input, 1, $4017 bit7 (0=4-step, 1=5-step).
REQ-008 SHALL have port irq_inhibit_in, input, 1, $4017 bit6.
REQ-009 SHALL have port status_rd, input, 1, $4015 read strobe. It is valid only when cpu_clk_en=1.
REQ-010 SHALL have outputs:
- quarter_clk_en, output, 1, envelope/linear clock pulse.
- half_clk_en, output, 1, length/sweep clock pulse.
- frame_irq, output, 1, frame IRQ flag.
- mode, output, 1, latched mode.

Function
REQ-011 SHALL hold a 15-bit step counter c, counting APU cycles. Terminal value T = 14914 when mode=0 and 18640 when mode=1.
REQ-012 SHALL, in a cycle with apu_clk_en=1 and no accepted write, set c to 0 if c==T and to c+1 otherwise. 4-step period = 14915 APU cycles; 5-step period = 18641 APU cycles.
REQ-013 SHALL assert quarter_clk_en combinationally in an apu_clk_en=1 cycle when c ∈ {3728, 7456, 11185, T}. The pulse is high for exactly that one clk cycle.
REQ-014 SHALL assert half_clk_en combinationally in an apu_clk_en=1 cycle when c ∈ {7456, T}.
REQ-015 SHALL accept a write when cpu_clk_en & mode_wr. On acceptance:
- mode <= mode_in;
- c <= 0;
- the REQ-013/014 decode is suppressed for that cycle, write wins over a coincident step.
REQ-016 SHALL, on an accepted write with mode_in=1, set a pending flag. In the next cycle with apu_clk_en=1, quarter_clk_en and half_clk_en SHALL both be asserted and the flag cleared; c still increments in that cycle. An accepted write with mode_in=0 SHALL clear the pending flag.
REQ-017 SHALL latch irq_inhibit on an accepted write. An accepted write with irq_inhibit_in=1 SHALL clear frame_irq in the next cycle.
REQ-018 SHALL set frame_irq (registered, visible next clk) in an apu_clk_en cycle when mode=0, irq_inhibit=0, c==14914 and no write is accepted.
REQ-019 SHALL clear frame_irq on cpu_clk_en & status_rd. If a set (REQ-018) and a clear coincide, set wins.
REQ-020 SHALL keep frame_irq at 0 in 5-step mode except for a flag already set before a write to mode=1; that flag clears only via REQ-017/019.
REQ-021 SHALL hold all state when apu_clk_en=0 except for write/read effects (REQ-015..019).
REQ-022 SHALL never assert quarter_clk_en or half_clk_en in a cycle where apu_clk_en=0.

Reset
REQ-023 SHALL, while rst_l=0, force c=0, mode=0, irq_inhibit=0, pending=0 and frame_irq=0. quarter_clk_en and half_clk_en SHALL be 0.
REQ-024 SHALL resume counting from c=0 on the first apu_clk_en after rst_l deasserts. Reset asserted mid-sequence discards any pending pulse and IRQ.

Verification
REQ-025 Reset, mode 0, free-run 2 full periods:
- quarter at APU cycles 3728/7456/11185/14914, half at 7456/14914;
- next quarter at 14915+3728;
- frame_irq rises 1 clk after cycle 14914.
REQ-026 Write mode_in=1, irq_inhibit_in=0:
- quarter+half on the next apu_clk_en;
- then quarter at 3728/7456/11185/18640, half at 7456/18640;
- frame_irq stays 0 for 3 periods.
REQ-027 Mode 0 with frame_irq=1:
- status_rd -> frame_irq=0 next clk;
- status_rd coincident with the c=14914 step -> frame_irq stays 1.
REQ-028 Mode 0, write irq_inhibit_in=1, mode_in=0 -> frame_irq cleared; no IRQ across 2 periods; quarter/half timing restarts from c=0.
REQ-029 Write accepted in the same cycle as the c=7456 step -> no quarter/half that cycle; c=0 afterward.
REQ-030 Assert rst_l=0 at c=9000 with a pending 5-step pulse -> all outputs 0; after release, first quarter arrives 3728 APU cycles later in mode 0.
